// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store responder with wait states and internal word RAM
// Optional macro MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of force-aligning them.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_busy,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] LAST_CNT = LAST_I[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_is_rd;
  logic [2:0]    r_func3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rd_word;
  logic          r_busy;
  logic          r_rd_valid;
  logic [31:0]   r_rdata;
  logic          r_misalign;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_misaligned;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic          w_unused_addr_bits;

  assign w_req = req_rd | req_wr;
  assign w_idx = r_addr[AW+1:2];
  assign w_unused_addr_bits = ^addr[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = (func3[1:0] == 2'b01) ? addr[0] :
                        (func3[1] ? (addr[1:0] != 2'b00) : 1'b0);
`else
  assign w_misaligned = 1'b0;
`endif

  // Lane enables ignore the low address bits a size cannot use, which force-aligns H and W.
  always_comb begin
    w_be    = 4'b1111;
    w_wword = r_wdata;
    case (r_func3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wword = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wword = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = r_rd_word[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = r_rd_word[7:0];
      2'b01:   w_byte = r_rd_word[15:8];
      2'b10:   w_byte = r_rd_word[23:16];
      default: w_byte = r_rd_word[31:24];
    endcase
    w_half = r_addr[1] ? r_rd_word[31:16] : r_rd_word[15:0];
    case (r_func3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = r_rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS) begin
      if (!r_is_rd) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
        end
      end
      r_rd_word <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_is_rd    <= 1'b0;
      r_func3    <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rdata    <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req && w_misaligned) begin
            r_misalign <= 1'b1;
          end else if (w_req) begin
            r_is_rd <= req_rd;
            r_func3 <= func3;
            r_addr  <= addr[AW+1:0];
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt   <= 4'd0;
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ACCESS: r_state <= S_RESP;
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_is_rd) begin
            r_rd_valid <= 1'b1;
            r_rdata    <= w_load;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_busy = r_busy;
  assign rd_valid = r_rd_valid;
  assign rdata    = r_rdata;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed and random load/store checks against a byte-array model
// Honours MISALIGN_TRAP_EN when defined for the whole build.
module tb_data_mem_ctrl;

  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        mem_busy;
  logic [31:0] rdata;
  logic        rd_valid;
  logic        misalign;

  int total = 0;
  int bad = 0;
  logic [7:0]  m [NBYTE];
  logic [31:0] last_rdata = 32'h0;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .func3(func3),
    .addr(addr), .wdata(wdata), .mem_busy(mem_busy), .rdata(rdata),
    .rd_valid(rd_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int base = (a % NBYTE) / sz * sz;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(m[base + i]) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz = size_of(f3);
    int base = (a % NBYTE) / sz * sz;
    for (int i = 0; i < sz; i++) m[base + i] = wd[8*i +: 8];
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic trap;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (a % size_of(f3)) != 0;
`endif
    @(negedge clk);
    req_rd = rd; req_wr = wr; func3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0;
    chk("misalign", {31'h0, misalign}, {31'h0, trap});
    n = 0;
    while (mem_busy === 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_cycles", n, trap ? 0 : WS + 2);
    if (!trap) begin
      if (rd) last_rdata = model_load(f3, a);
      else model_store(f3, a, wd);
    end
    chk("rd_valid", {31'h0, rd_valid}, {31'h0, rd & ~trap});
    chk("rdata", rdata, last_rdata);
    @(posedge clk); #1;
    chk("pulse_end", {30'h0, rd_valid, misalign}, 32'h0);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {mem_busy, rd_valid, misalign}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int w = 0; w < DEPTH; w++) do_op(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("t1_lw", rdata, 32'hDEADBEEF);

    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344);
    do_op(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b000, 32'h11, 32'h0);
    chk("t2_lb", rdata, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
    chk("t2_lbu", rdata, 32'h00000080);
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("t2_lw", rdata, 32'h11228044);

    do_op(1'b0, 1'b1, 3'b010, 32'h20, 32'h1234ABCD);
    do_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h55558001);
    do_op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    chk("t3_lh", rdata, 32'hFFFF8001);
    do_op(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
    chk("t3_lhu", rdata, 32'h00008001);
    do_op(1'b1, 1'b0, 3'b001, 32'h20, 32'h0);
    chk("t3_lh_low", rdata, 32'hFFFFABCD);

    do_op(1'b0, 1'b1, 3'b010, 32'h30, 32'hAAAAAAAA);
    do_op(1'b1, 1'b1, 3'b010, 32'h30, 32'h5);
    chk("t4_both", rdata, 32'hAAAAAAAA);
    do_op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    chk("t4_after", rdata, 32'hAAAAAAAA);

    do_op(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    req_wr = 1'b1; func3 = 3'b010; addr = 32'h40; wdata = 32'h12345678;
    @(posedge clk); #1;
    req_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    last_rdata = 32'h0;
    chk("t5_busy", {31'h0, mem_busy}, 32'h0);
    chk("t5_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b1;
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    chk("t5_kept", rdata, 32'hCAFEF00D);

    do_op(1'b1, 1'b0, 3'b010, 32'h13, 32'h0);
    do_op(1'b1, 1'b0, 3'b010, 32'h10 + 32'(NBYTE), 32'h0);
    chk("wrap", rdata, 32'h11228044);

    for (int k = 0; k < 300; k++) begin
      int kind = $urandom_range(0, 9);
      do_op(kind < 5 || kind == 9, kind >= 5, f3_tab[$urandom_range(0, 7)], $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory responder for the pipeline's load/store requests; the pipeline controller is the initiator and this block is the responder.
- Accepts one read or write per transaction.
- Holds mem_busy high while the access is in flight, including a configurable number of wait states.
- Returns load data aligned and extended according to func3.
- Contains the backing word-organised RAM.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the internal RAM (power of two)
WAIT_STATES, 2, extra cycles inserted before each access completes (0..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_rd  input  1  load request, sampled in IDLE only
req_wr  input  1  store request, sampled in IDLE only
func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address
wdata  input  32  store data, low bytes used for B/H
mem_busy  output  1  transaction in progress; pipeline must hold request fields stable
rdata  output  32  load result, extended; valid when rd_valid=1
rd_valid  output  1  one-cycle pulse when a load completes
misalign  output  1  one-cycle pulse on a rejected misaligned access (MISALIGN_TRAP_EN only)

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_busy=0, rd_valid=0, rdata=0, misalign=0, state=IDLE, wait counter=0.
  - RAM contents are not cleared.
- State machine IDLE -> WAIT -> ACCESS -> IDLE:
  - IDLE:
    - On a rising edge with req_rd|req_wr=1: latch addr, func3, wdata and the op, and set mem_busy=1.
    - Go to WAIT if WAIT_STATES>0, else to ACCESS.
  - WAIT: the counter counts from 0 up to WAIT_STATES-1. The edge at the terminal count moves to ACCESS.
  - ACCESS:
    - Perform the RAM read or write using the latched fields.
    - On the next edge: mem_busy=0, return to IDLE, and pulse rd_valid=1 for a load (load data is placed on rdata on this same edge).
- Latency: mem_busy is high for exactly WAIT_STATES+2 cycles, counted from the edge after the request is sampled.
- A new request is accepted no earlier than the first edge at which mem_busy is seen low.
- Simultaneous req_rd and req_wr: the read wins and the write is dropped.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Stores:
  - B writes byte lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - W writes all 4 lanes.
  - Untouched lanes are preserved via read-modify-write of the word.
- Loads:
  - The selected byte/half is shifted down to bit 0.
  - B and H are sign-extended from bit 7 / 15.
  - BU and HU are zero-extended.
  - W is passed unchanged.
- Illegal func3 (011, 110, 111) is treated as W.
- rdata holds its last load value until the next load completes. Stores do not alter rdata.
- Reset asserted mid-transaction: the transaction is abandoned, outputs go to their reset values, and a partial store may be lost. A store whose ACCESS edge has already occurred is kept.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Misaligned accesses are H/HU with addr[0]=1, and W with addr[1:0]!=0.
  - A misaligned access is detected in IDLE when the request is sampled. On that edge: misalign=1 for one cycle, mem_busy stays 0, RAM is unchanged, rd_valid is not pulsed, and the state stays IDLE.
- Undefined:
  - The misalign port is tied 0.
  - Misaligned addresses are force-aligned: addr[0] is cleared for H, addr[1:0] are cleared for W.
  - The access then proceeds normally.

Test Plan:
1. Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (WAIT_STATES=2) -> mem_busy high 4 cycles for each op; rd_valid pulse with rdata=0xDEADBEEF.
2. SB addr=0x11 wdata=0x80 over word 0x11223344 at 0x10, then LB addr=0x11 -> rdata=0xFFFFFF80; LBU addr=0x11 -> rdata=0x00000080; LW 0x10 -> 0x11228044.
3. SH addr=0x22 wdata=0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x20 -> the original lower half.
4. req_rd and req_wr both 1 at addr 0x30 (RAM word 0xAAAAAAAA, wdata=0x5) -> the read completes with rdata=0xAAAAAAAA; LW 0x30 afterwards still returns 0xAAAAAAAA.
5. Pulse rst low during WAIT of an SW to 0x40 -> mem_busy=0 immediately; after release, LW 0x40 returns the prior contents; the next request is accepted normally.
6. With MISALIGN_TRAP_EN, LW addr=0x13 -> misalign=1 for one cycle, mem_busy never rises. Without it, the same access reads word 0x10.
